// File: rtl/rom_dl_ctrl.sv
// ROM download controller: steers the ioctl byte stream into ROM, mod and DIP
// registers and sequences the game-core reset around ROM downloads.
module rom_dl_ctrl #(
    parameter int ROM_BYTES = 98304,
    parameter int RST_HOLD  = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic        user_reset,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [7:0]  dipsw,
    output logic        mod_sbag,
    output logic        mod_pick,
    output logic        mod_squa,
    output logic        core_reset,
    output logic        dl_error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int          CW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_INIT = CW'(RST_HOLD - 1);
    localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);

    // Reset asserts asynchronously but releases two clk_sys edges later.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dl_start;
    logic            load_entry;
    logic            core_reset_q, core_reset_d;

    assign dl_start = ioctl_download && (ioctl_index == 8'd0);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT, ST_RUN: begin
                if (dl_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (dl_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        load_entry   = (state_q != ST_LOAD) && (state_d == ST_LOAD);
        core_reset_d = (state_q != ST_RUN) || user_reset;
    end

    logic        rom_req, rom_ok;
    logic        dn_wr_q, dn_wr_d;
    logic [16:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic        dl_error_q, dl_error_d;
    logic [7:0]  mod_q, mod_d;
    logic [2:0]  flags_q, flags_d;
    logic [7:0]  dipsw_q, dipsw_d;

    always_comb begin
        rom_req    = ioctl_wr && (ioctl_index == 8'd0);
        rom_ok     = rom_req && (ioctl_addr < ROM_LIMIT);
        dn_wr_d    = rom_ok;
        dn_addr_d  = dn_addr_q;
        dn_data_d  = dn_data_q;
        if (rom_ok) begin
            dn_addr_d = ioctl_addr[16:0];
            dn_data_d = ioctl_dout;
        end
        // An out-of-range write on the LOAD entry cycle must still be flagged.
        if (rom_req && !rom_ok) dl_error_d = 1'b1;
        else if (load_entry)    dl_error_d = 1'b0;
        else                    dl_error_d = dl_error_q;

        mod_d = mod_q;
        if (ioctl_wr && (ioctl_index == 8'd1)) mod_d = ioctl_dout;
        flags_d = {mod_q == 8'd3, mod_q == 8'd2, mod_q == 8'd1};

        dipsw_d = dipsw_q;
        if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr == 25'd0))
            dipsw_d = ioctl_dout;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            core_reset_q <= 1'b1;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dl_error_q   <= 1'b0;
            mod_q        <= '0;
            flags_q      <= '0;
            dipsw_q      <= 8'h00;
        end else begin
            core_reset_q <= core_reset_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dl_error_q   <= dl_error_d;
            mod_q        <= mod_d;
            flags_q      <= flags_d;
            dipsw_q      <= dipsw_d;
        end
    end

    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dl_error   = dl_error_q;
    assign dipsw      = dipsw_q;
    assign mod_sbag   = flags_q[0];
    assign mod_pick   = flags_q[1];
    assign mod_squa   = flags_q[2];
    assign core_reset = core_reset_q;
    assign dbg_state  = state_q;

endmodule
